// File: rtl/systolic_array_ctrl.sv
// Job sequencer for one systolic_array: load A, load B, compute, flush, drain C, done.
// Latency: LOAD/DRAIN are zero-latency pass-through; COMPUTE lasts compute_cycles_p cycles; FLUSH and DONE are one cycle each.
// Backpressure: arr_ready_i=0 stalls LOAD (ready_o follows it); yumi_i=0 holds DRAIN indefinitely. SA_CTRL_PERF_EN enables the job cycle counter.
module systolic_array_ctrl #(
    parameter int width_p          = 8,
    parameter int array_width_p    = 8,
    parameter int array_height_p   = 8,
    parameter int compute_cycles_p = 16
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               start_i,
    output logic               busy_o,
    output logic               done_o,
    input  logic               valid_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               arr_en_o,
    output logic               arr_valid_o,
    output logic [width_p-1:0] arr_data_o,
    input  logic               arr_ready_i,
    output logic               arr_flush_o,
    input  logic               arr_valid_i,
    input  logic [width_p-1:0] arr_data_i,
    output logic               arr_yumi_o,
    output logic               valid_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i,
    output logic [31:0]        perf_cycles_o
);

    localparam int num_macs = array_width_p * array_height_p;
    localparam int num_res  = array_height_p * array_height_p;
    // Sized for the larger of the load and drain counts so tall arrays still fit.
    localparam int cnt_max  = (num_macs > num_res) ? num_macs : num_res;
    localparam int cnt_w    = $clog2(cnt_max + 1);

    localparam logic [cnt_w-1:0] load_last  = cnt_w'(num_macs - 1);
    localparam logic [cnt_w-1:0] drain_last = cnt_w'(num_res - 1);
    localparam logic [15:0]      comp_last  = 16'(compute_cycles_p - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_A  = 3'd1,
        LOAD_B  = 3'd2,
        COMPUTE = 3'd3,
        FLUSH   = 3'd4,
        DRAIN   = 3'd5,
        DONE    = 3'd6
    } state_t;

    state_t           state, state_n;
    logic [cnt_w-1:0] load_cnt, drain_cnt;
    logic [15:0]      comp_cnt;
    logic             in_load, accept, xfer;

    assign in_load  = (state == LOAD_A) || (state == LOAD_B);
    assign accept   = in_load && valid_i && arr_ready_i;
    assign xfer     = (state == DRAIN) && arr_valid_i && yumi_i;
    assign busy_o   = (state != IDLE);
    assign arr_en_o = busy_o;

    // State register; reset aborts any job in flight.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) state <= IDLE;
        else          state <= state_n;
    end

    // Load, compute and drain counters; each wraps to zero as its phase completes.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            load_cnt  <= '0;
            comp_cnt  <= '0;
            drain_cnt <= '0;
        end else begin
            if (accept)
                load_cnt <= (load_cnt == load_last) ? '0 : load_cnt + 1'b1;
            if (state == COMPUTE)
                comp_cnt <= (comp_cnt == comp_last) ? '0 : comp_cnt + 16'd1;
            if (xfer)
                drain_cnt <= (drain_cnt == drain_last) ? '0 : drain_cnt + 1'b1;
        end
    end

    // Next-state and per-state pass-through of the upstream and result handshakes.
    always_comb begin
        state_n     = state;
        done_o      = 1'b0;
        ready_o     = 1'b0;
        arr_valid_o = 1'b0;
        arr_data_o  = '0;
        arr_flush_o = 1'b0;
        arr_yumi_o  = 1'b0;
        valid_o     = 1'b0;
        data_o      = '0;
        case (state)
            IDLE: begin
                if (start_i) state_n = LOAD_A;
            end
            LOAD_A, LOAD_B: begin
                ready_o     = arr_ready_i;
                arr_valid_o = valid_i;
                arr_data_o  = data_i;
                if (accept && (load_cnt == load_last))
                    state_n = (state == LOAD_A) ? LOAD_B : COMPUTE;
            end
            COMPUTE: begin
                if (comp_cnt == comp_last) state_n = FLUSH;
            end
            FLUSH: begin
                arr_flush_o = 1'b1;
                state_n     = DRAIN;
            end
            DRAIN: begin
                arr_flush_o = 1'b1;
                valid_o     = arr_valid_i;
                data_o      = arr_data_i;
                arr_yumi_o  = yumi_i & arr_valid_i;
                if (xfer && (drain_cnt == drain_last)) state_n = DONE;
            end
            DONE: begin
                done_o  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef SA_CTRL_PERF_EN
    logic [31:0] perf_cnt;

    // Busy-cycle counter: cleared at job start, counts through DONE, then holds; saturates.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i)
            perf_cnt <= '0;
        else if ((state == IDLE) && start_i)
            perf_cnt <= '0;
        else if (busy_o && (perf_cnt != 32'hFFFF_FFFF))
            perf_cnt <= perf_cnt + 32'd1;
    end

    assign perf_cycles_o = perf_cnt;
`else
    assign perf_cycles_o = '0;
`endif

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Bench for systolic_array_ctrl in a 2x2 configuration with compute_cycles_p=4.
// The bench plays upstream source, array model and result consumer; a negedge monitor scores both data paths.
// Scenarios: clean job, LOAD back-pressure, DRAIN stall, reset mid-LOAD_B, start pulses while busy.
module tb_systolic_array_ctrl;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        start_i = 1'b0;
    logic        busy_o, done_o;
    logic        valid_i = 1'b0;
    logic [7:0]  data_i = 8'h00;
    logic        ready_o;
    logic        arr_en_o, arr_valid_o;
    logic [7:0]  arr_data_o;
    logic        arr_ready_i = 1'b1;
    logic        arr_flush_o;
    logic        arr_valid_i;
    logic [7:0]  arr_data_i;
    logic        arr_yumi_o;
    logic        valid_o;
    logic [7:0]  data_o;
    logic        yumi_i = 1'b1;
    logic [31:0] perf_cycles_o;

    always #5 clk_i = ~clk_i;

    systolic_array_ctrl #(
        .width_p(8), .array_width_p(2), .array_height_p(2), .compute_cycles_p(4)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
        .valid_i(valid_i), .data_i(data_i), .ready_o(ready_o),
        .arr_en_o(arr_en_o), .arr_valid_o(arr_valid_o), .arr_data_o(arr_data_o),
        .arr_ready_i(arr_ready_i), .arr_flush_o(arr_flush_o),
        .arr_valid_i(arr_valid_i), .arr_data_i(arr_data_i), .arr_yumi_o(arr_yumi_o),
        .valid_o(valid_o), .data_o(data_o), .yumi_i(yumi_i), .perf_cycles_o(perf_cycles_o)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_in[$];
    logic [7:0] exp_out[$];
    int acc_cnt = 0, res_cnt = 0, done_cnt = 0, since_acc = 0, jobs = 0;
    logic flush_seen = 1'b0;
    logic tog_mode = 1'b0;

    // Array model: C = A*B for A={1,2,3,4}, B={5,6,7,8}, presented once flush is raised.
    logic [7:0] c_mem [4];
    logic [2:0] c_idx;
    initial begin
        c_mem[0] = 8'd19; c_mem[1] = 8'd22; c_mem[2] = 8'd43; c_mem[3] = 8'd50;
    end
    assign arr_valid_i = arr_flush_o && (c_idx < 3'd4);
    assign arr_data_i  = (c_idx < 3'd4) ? c_mem[c_idx[1:0]] : 8'h00;

    always @(posedge clk_i or negedge reset_i) begin
        if (!reset_i)                 c_idx <= 3'd0;
        else if (start_i && !busy_o)  c_idx <= 3'd0;
        else if (arr_yumi_o)          c_idx <= c_idx + 3'd1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Array ready: constant 1, or toggling every cycle when tog_mode is set.
    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            arr_ready_i = tog_mode ? ~arr_ready_i : 1'b1;
        end
    end

    // Monitor: scores array-side accepts and consumer-side results against the queues.
    always @(negedge clk_i) begin
        if (reset_i) begin
            if (start_i && !busy_o) begin
                acc_cnt = 0; res_cnt = 0; since_acc = 0; flush_seen = 1'b0;
            end
            since_acc++;
            if (arr_valid_o && arr_ready_i) begin
                if (exp_in.size() == 0) chk("unexpected_accept", 32'(arr_data_o), 32'hFFFF);
                else                    chk("arr_data", 32'(arr_data_o), 32'(exp_in.pop_front()));
                acc_cnt++;
                since_acc = 0;
            end
            if (arr_flush_o && !flush_seen) begin
                flush_seen = 1'b1;
                chk("accepts_before_flush", 32'(acc_cnt), 32'd8);
                chk("compute_gap", 32'(since_acc), 32'd5);
            end
            if (valid_o && yumi_i) begin
                chk("flush_in_drain", 32'(arr_flush_o), 32'd1);
                chk("arr_yumi", 32'(arr_yumi_o), 32'd1);
                if (exp_out.size() == 0) chk("unexpected_result", 32'(data_o), 32'hFFFF);
                else                     chk("result", 32'(data_o), 32'(exp_out.pop_front()));
                res_cnt++;
            end
            if (done_o) begin
                done_cnt++;
                chk("busy_in_done", 32'(busy_o), 32'd1);
            end
        end
    end

    task automatic chk_all_zero(input string name);
        chk(name, 32'({busy_o, done_o, ready_o, arr_en_o, arr_valid_o, arr_flush_o, arr_yumi_o,
                       valid_o, data_o, arr_data_o} != '0) | 32'(perf_cycles_o != 0), 32'd0);
    endtask

    task automatic start_job();
        @(posedge clk_i); #1;
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        chk("busy_after_start", 32'(busy_o), 32'd1);
    endtask

    task automatic send(input logic [7:0] d);
        int n = 0;
        exp_in.push_back(d);
        valid_i = 1'b1;
        data_i  = d;
        do begin
            @(negedge clk_i);
            n++;
        end while (!ready_o && n < 100);
        if (n >= 100) chk("send_timeout", 32'(n), 32'd0);
        @(posedge clk_i); #1;
        valid_i = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_cnt < jobs && n < 300) begin
            @(negedge clk_i);
            n++;
        end
        chk("done_count", 32'(done_cnt), 32'(jobs));
        @(negedge clk_i);
        chk("done_one_cycle", 32'(done_o), 32'd0);
        chk("idle_after_done", 32'(busy_o), 32'd0);
        chk("results_per_job", 32'(res_cnt), 32'd4);
        chk("exp_out_drained", 32'(exp_out.size()), 32'd0);
    endtask

    task automatic run_job(input bit stall, input bit pulse);
        int n;
        for (int i = 0; i < 4; i++) exp_out.push_back(c_mem[i]);
        jobs++;
        start_job();
        for (int i = 1; i <= 8; i++) send(8'(i));
        tog_mode = 1'b0;
        if (pulse) begin
            start_i = 1'b1;
            @(posedge clk_i); #1;
            start_i = 1'b0;
        end
        if (stall) begin
            n = 0;
            while (res_cnt < 2 && n < 100) begin @(negedge clk_i); n++; end
            @(posedge clk_i); #1;
            yumi_i = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk_i);
                if (i == 0 || i == 9) begin
                    chk("stall_flush", 32'(arr_flush_o), 32'd1);
                    chk("stall_valid", 32'(valid_o), 32'd1);
                    chk("stall_no_yumi", 32'(arr_yumi_o), 32'd0);
                end
            end
            @(posedge clk_i); #1;
            yumi_i = 1'b1;
        end
        if (pulse) begin
            n = 0;
            while (!done_o && n < 300) begin @(negedge clk_i); n++; end
            start_i = 1'b1;
            @(posedge clk_i); #1;
            start_i = 1'b0;
        end
        wait_done();
        if (pulse) begin
            repeat (5) @(negedge clk_i);
            chk("no_second_job", 32'(busy_o), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk_all_zero("reset_outputs");
        @(posedge clk_i); #1;
        reset_i = 1'b1;

        // Clean job; perf counter holds the inclusive busy-cycle count in IDLE.
        run_job(1'b0, 1'b0);
`ifdef SA_CTRL_PERF_EN
        chk("perf_cycles", perf_cycles_o, 32'd18);
        repeat (3) @(negedge clk_i);
        chk("perf_hold", perf_cycles_o, 32'd18);
`else
        chk("perf_zero", perf_cycles_o, 32'd0);
`endif

        // Array ready toggling during both load phases.
        tog_mode = 1'b1;
        run_job(1'b0, 1'b0);

        // Consumer stall mid-drain.
        run_job(1'b1, 1'b0);

        // Reset after two B elements, then a full job must reload all 8.
        start_job();
        for (int i = 1; i <= 6; i++) send(8'(i));
        #2;
        reset_i = 1'b0;
        #1;
        chk_all_zero("midjob_reset_outputs");
        @(posedge clk_i); #1;
        reset_i = 1'b1;
        run_job(1'b0, 1'b0);

        // start pulses during COMPUTE and DONE are ignored.
        run_job(1'b0, 1'b1);

        chk("exp_in_drained", 32'(exp_in.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
